// File: rtl/vblank_update_scheduler_pkg.sv
// Shared constants for the asteroids game-object update path.
// Row limits, client indices and scheduler state encodings.
package asteroids_pkg;

    localparam int V_ACTIVE    = 480;
    localparam int NUM_CLIENTS = 3;

    localparam int CL_SHIP   = 0;
    localparam int CL_BULLET = 1;
    localparam int CL_ROCK   = 2;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SELECT = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

endpackage

// File: rtl/vblank_update_scheduler_if.sv
// Client handshake bundle between the vblank scheduler and the
// game-object update modules.
interface vblank_update_scheduler_if #(
    parameter int N_CLIENTS = 3
);

    logic [N_CLIENTS-1:0] iReq;
    logic [N_CLIENTS-1:0] iDone;
    logic [N_CLIENTS-1:0] oStart;

    modport master (
        input  iReq,
        input  iDone,
        output oStart
    );

    modport slave (
        output iReq,
        output iDone,
        input  oStart
    );

endinterface

// File: rtl/vblank_update_scheduler_first_one.sv
// Lowest-set-bit finder: one-hot mask of the lowest set bit of vec
// and its index (zero when vec is empty).
module first_one #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  vec,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx
);

    assign onehot = vec & (~vec + N'(1));

    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/vblank_update_scheduler.sv
// Grants per-frame object update slots in fixed priority order,
// only while vga_sync is in vertical blank.
module vblank_update_scheduler #(
    parameter int N_CLIENTS = asteroids_pkg::NUM_CLIENTS,
    parameter int V_ACTIVE  = asteroids_pkg::V_ACTIVE,
    parameter int TIMEOUT   = 1024,
    parameter int FRAME_W   = 16
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic [9:0]           iPy,
    input  logic                 iEnable,
    input  logic                 iClear,
    vblank_update_scheduler_if.master cl,
    output logic                 oBusy,
    output logic [FRAME_W-1:0]   oFrame,
    output logic                 oOverrun,
    output logic [N_CLIENTS-1:0] oTimeout
);

    import asteroids_pkg::*;

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int IW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

    logic [1:0]           state;
    logic [9:0]           py_q;
    logic [N_CLIENTS-1:0] pend;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        cur;
    logic [N_CLIENTS-1:0] sel_oh;
    logic [IW-1:0]        sel_idx;
    logic                 vb_edge;
    logic                 act_edge;

    first_one #(.N(N_CLIENTS), .IW(IW)) u_first (
        .vec    (pend),
        .onehot (sel_oh),
        .idx    (sel_idx)
    );

    assign vb_edge  = (iPy == 10'(V_ACTIVE)) && (py_q != 10'(V_ACTIVE));
    assign act_edge = (iPy == 10'd0) && (py_q != 10'd0);
    assign oBusy    = (state != IDLE);

    // A start that collides with the start of active video is dropped
    assign cl.oStart = (state == SELECT && !act_edge && !iRST)
                     ? sel_oh : '0;

    always_ff @(posedge iCLK) begin
        if (iRST) py_q <= '0;
        else      py_q <= iPy;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state    <= IDLE;
            pend     <= '0;
            cnt      <= '0;
            cur      <= '0;
            oFrame   <= '0;
            oOverrun <= 1'b0;
            oTimeout <= '0;
        end else begin
            if (iClear) begin
                oOverrun <= 1'b0;
                oTimeout <= '0;
            end
            if (state != IDLE && act_edge) begin
                oOverrun <= 1'b1;
                pend     <= '0;
                state    <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (vb_edge && iEnable) begin
                            pend  <= cl.iReq;
                            state <= SELECT;
                        end
                    end
                    SELECT: begin
                        if (pend == '0) begin
                            state <= DONE;
                        end else begin
                            pend  <= pend & ~sel_oh;
                            cur   <= sel_idx;
                            cnt   <= '0;
                            state <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (cl.iDone[cur]) begin
                            state <= SELECT;
                        end else if (cnt == CW'(TIMEOUT - 1)) begin
                            oTimeout[cur] <= 1'b1;
                            state         <= SELECT;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    DONE: begin
                        oFrame <= oFrame + FRAME_W'(1);
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vblank_update_scheduler.sv
// Directed bench for vblank_update_scheduler; start pulses are
// checked against a queue of expected grants.
module tb_vblank_update_scheduler;

    import asteroids_pkg::*;

    localparam int NC = 3;
    localparam int FW = 8;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [9:0]    py;
    logic          en;
    logic          clr;
    logic          busy;
    logic [FW-1:0] frame;
    logic          ovr;
    logic [NC-1:0] tmo;

    int n_checks = 0;
    int n_pass   = 0;

    logic [NC-1:0] exp_q[$];

    vblank_update_scheduler_if #(.N_CLIENTS(NC)) cl_if ();

    vblank_update_scheduler #(
        .N_CLIENTS (NC),
        .V_ACTIVE  (480),
        .TIMEOUT   (TO),
        .FRAME_W   (FW)
    ) dut (
        .iCLK     (clk),
        .iRST     (rst),
        .iPy      (py),
        .iEnable  (en),
        .iClear   (clr),
        .cl       (cl_if.master),
        .oBusy    (busy),
        .oFrame   (frame),
        .oOverrun (ovr),
        .oTimeout (tmo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy) break;
            tick();
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Scoreboard: every start pulse must match the next expected grant
    always @(negedge clk) begin
        if (cl_if.oStart != '0) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_start", 32'(cl_if.oStart), 32'd0);
            end else begin
                chk("sb_start", 32'(cl_if.oStart), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst = 1'b1;
        py  = '0;
        en  = 1'b0;
        clr = 1'b0;
        cl_if.iReq  = '0;
        cl_if.iDone = '0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame", 32'(frame), 0);
        chk("rst_ovr", 32'(ovr), 0);
        chk("rst_tmo", 32'(tmo), 0);
        chk("rst_start", 32'(cl_if.oStart), 0);
        rst = 1'b0;
        en  = 1'b1;

        // Normal sequence: clients 0 and 2
        py = 10'd479;
        tick();
        cl_if.iReq = 3'b101;
        exp_q.push_back(NC'(1 << CL_SHIP));
        exp_q.push_back(NC'(1 << CL_ROCK));
        py = 10'd480;
        tick();
        chk("n_start0", 32'(cl_if.oStart), 32'b001);
        chk("n_busy", 32'(busy), 1);
        tick();
        cl_if.iReq = 3'b111;
        en = 1'b0;
        tick();
        tick();
        tick();
        cl_if.iDone = 3'b001;
        tick();
        cl_if.iDone = 3'b000;
        chk("n_start2", 32'(cl_if.oStart), 32'b100);
        tick();
        cl_if.iDone = 3'b110;
        tick();
        cl_if.iDone = 3'b000;
        chk("n_empty_sel", 32'(cl_if.oStart), 0);
        tick();
        chk("n_frame_pre", 32'(frame), 0);
        tick();
        chk("n_frame", 32'(frame), 1);
        chk("n_idle", 32'(busy), 0);
        en = 1'b1;
        cl_if.iReq = 3'b000;

        // Row held at 480: edge seen once only
        repeat (10) tick();
        chk("reentry_busy", 32'(busy), 0);
        chk("reentry_frame", 32'(frame), 1);

        // Timeout on client 1, set beats simultaneous clear
        py = 10'd479;
        tick();
        cl_if.iReq = 3'b010;
        exp_q.push_back(NC'(1 << CL_BULLET));
        py = 10'd480;
        tick();
        repeat (TO) tick();
        chk("to_last_wait", 32'(tmo), 0);
        chk("to_busy", 32'(busy), 1);
        clr = 1'b1;
        tick();
        chk("to_flag", 32'(tmo), 32'b010);
        chk("to_no_start", 32'(cl_if.oStart), 0);
        tick();
        chk("to_cleared", 32'(tmo), 0);
        clr = 1'b0;
        wait_idle(10);
        chk("to_frame", 32'(frame), 2);

        // Overrun during WAIT
        py = 10'd479;
        tick();
        cl_if.iReq = 3'b001;
        exp_q.push_back(NC'(1 << CL_SHIP));
        py = 10'd480;
        tick();
        tick();
        tick();
        tick();
        py = 10'd0;
        tick();
        chk("ov_flag", 32'(ovr), 1);
        chk("ov_idle", 32'(busy), 0);
        chk("ov_frame", 32'(frame), 2);

        // Next frame runs normally with minimum-length slots
        py = 10'd479;
        tick();
        cl_if.iReq  = 3'b011;
        cl_if.iDone = 3'b011;
        exp_q.push_back(NC'(1 << CL_SHIP));
        exp_q.push_back(NC'(1 << CL_BULLET));
        py = 10'd480;
        tick();
        wait_idle(20);
        cl_if.iDone = 3'b000;
        chk("post_ov_frame", 32'(frame), 3);
        chk("ov_sticky", 32'(ovr), 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("ov_clear", 32'(ovr), 0);

        // Active video starts in the SELECT cycle: start suppressed
        py = 10'd479;
        tick();
        cl_if.iReq = 3'b001;
        py = 10'd480;
        tick();
        py = 10'd0;
        #1;
        chk("sup_start", 32'(cl_if.oStart), 0);
        tick();
        chk("sup_ovr", 32'(ovr), 1);
        chk("sup_idle", 32'(busy), 0);
        chk("sup_frame", 32'(frame), 3);

        // Disabled across a vblank edge
        en = 1'b0;
        py = 10'd479;
        tick();
        py = 10'd480;
        tick();
        chk("gate_busy0", 32'(busy), 0);
        repeat (3) tick();
        chk("gate_busy1", 32'(busy), 0);
        en = 1'b1;

        // Reset during WAIT
        py = 10'd479;
        tick();
        cl_if.iReq = 3'b001;
        exp_q.push_back(NC'(1 << CL_SHIP));
        py = 10'd480;
        tick();
        tick();
        tick();
        rst = 1'b1;
        py  = 10'd479;
        tick();
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_frame", 32'(frame), 0);
        chk("mrst_ovr", 32'(ovr), 0);
        chk("mrst_tmo", 32'(tmo), 0);
        chk("mrst_start", 32'(cl_if.oStart), 0);
        tick();
        rst = 1'b0;
        cl_if.iReq = 3'b000;
        tick();
        chk("mrst_stay", 32'(busy), 0);

        // Empty-request frames up to frame counter wrap
        for (int f = 0; f < (1 << FW); f++) begin
            py = 10'd479;
            tick();
            py = 10'd480;
            tick();
            tick();
            if (f == 0) chk("empty_t2", 32'(frame), 0);
            tick();
            if (f == 0) chk("empty_t3", 32'(frame), 1);
            if (f == (1 << FW) - 2) chk("wrap_max", 32'(frame), 32'hFF);
        end
        chk("wrap_zero", 32'(frame), 0);
        chk("sb_drained", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vblank_update_scheduler.md
# vblank_update_scheduler

Sequences per-frame object updates (ship, bullets, asteroids, …) so they run only during vertical blank, never while `vga_sync` is scanning pixels. On entry to vertical blank it latches the set of requesting clients. It then grants each one, in fixed index order, a one-cycle start pulse and waits for that client's done, bounded by a timeout. It sits between `vga_sync`'s pixel row output and the game-object modules, and all of them run on the VGA control clock.

## Interface
- `N_CLIENTS`, 3 — number of update clients; index 0 has highest priority.
- `V_ACTIVE`, 480 — first non-visible row value of `py`.
- `TIMEOUT`, 1024 — maximum cycles a client may hold its slot; must be ≥ 2.
- `FRAME_W`, 16 — width of the frame counter.

- `iCLK`  in  1  — VGA control clock; the only clock.
- `iRST`  in  1  — synchronous, active-high reset.
- `iPy`  in  10  — current row from `vga_sync`.
- `iEnable`  in  1  — when low, vblank edges are ignored.
- `iReq`  in  N_CLIENTS  — client wants a slot this frame; sampled only at SELECT entry.
- `iDone`  in  N_CLIENTS  — client finished; only the granted client's bit is honoured.
- `iClear`  in  1  — clears the sticky error flags.
- `oStart`  out  N_CLIENTS  — one-hot, one-cycle start pulse.
- `oBusy`  out  1  — high in every state except IDLE.
- `oFrame`  out  FRAME_W  — count of completed update sequences; wraps modulo 2^FRAME_W.
- `oOverrun`  out  1  — sticky; a sequence was still running when active video began.
- `oTimeout`  out  N_CLIENTS  — sticky per-client timeout flags.

## Operation
- **Reset values:** state IDLE; `oStart`=0; `oBusy`=0; `oFrame`=0; `oOverrun`=0; `oTimeout`=0; `py_q`=0; pending mask=0; timeout counter=0.
- **`py_q`:** registers `iPy` every cycle.
  - vblank edge = (`iPy`==V_ACTIVE) && (`py_q`!=V_ACTIVE).
  - active edge = (`iPy`==0) && (`py_q`!=0).
- **States:**
  - **IDLE:** on a vblank edge with `iEnable`=1, go to SELECT and load the pending mask from `iReq`. Otherwise stay.
  - **SELECT:** if the pending mask is 0, go to DONE. Otherwise:
    - choose the lowest set index i;
    - clear bit i from the mask;
    - drive `oStart[i]`=1 for exactly this cycle;
    - clear the timeout counter;
    - go to WAIT.
  - **WAIT:**
    - If `iDone[i]`=1, go to SELECT.
    - Else if counter==TIMEOUT−1, set `oTimeout[i]` and go to SELECT.
    - Else increment the counter.
    - `iDone` bits of other clients are ignored.
  - **DONE:** increment `oFrame` and go to IDLE.
- **Overrun:** an active edge in any state other than IDLE sets `oOverrun`, clears the pending mask and forces IDLE next cycle. That frame does not increment `oFrame`. A pending `oStart` pulse in the same cycle is suppressed.
- **Edges while not IDLE:** a vblank edge in a non-IDLE state is ignored.
- **Flag priority:** `iClear` clears `oOverrun` and `oTimeout`. If a set and an `iClear` occur in the same cycle, the set wins.
- **Mid-frame `iEnable` drop:** an in-progress sequence completes normally.
- **`iReq` changes:** changes after SELECT entry do not affect the current frame.
- **Reset:** `iRST` mid-sequence returns to the reset values on the next edge, with no `oStart` pulse.

## Timing
- Vblank edge at cycle t → SELECT at t+1. If the lowest requester is client i, `oStart[i]`=1 during t+1.
- `iDone[i]` sampled high at cycle d → next SELECT (and next `oStart`) at d+1.
- **Minimum slot:** 2 cycles (start cycle plus a done in the first WAIT cycle).
- **Timeout:** WAIT lasts at most TIMEOUT cycles; the flag is set on the last of them.
- **Frame count:** `oFrame` updates one cycle after the final SELECT that finds an empty mask.
- **Empty request set:** with `iReq`=0 at the edge, `oFrame` increments at t+3.

## Structure
- Shared package `asteroids_pkg`:
  - `V_ACTIVE`;
  - the state enum {IDLE, SELECT, WAIT, DONE};
  - `N_CLIENTS` client index constants (`CL_SHIP`=0, `CL_BULLET`=1, `CL_ROCK`=2).
- One sub-module `first_one`: parameterised lowest-set-bit finder returning a one-hot value and the index. It is combinational and is used in SELECT.
- Everything else lives in one always block plus the `py_q` register.

## Test plan
- **Normal sequence:** reset, `iReq`=3'b101, step `iPy` 479→480.
  - `oStart`=001 at t+1.
  - Client 0 done after 5 cycles → `oStart`=100 one cycle later.
  - Client 2 done → `oFrame`=1; client 1 never started.
- **Timeout:** TIMEOUT=8, `iReq`=3'b010, `iDone` held low.
  - `oTimeout`=010 after 8 WAIT cycles.
  - `oFrame`=1.
  - `iClear` → `oTimeout`=0.
- **Overrun:** client 0 never done, TIMEOUT large, `iPy` wraps to 0 during WAIT.
  - `oOverrun`=1 and IDLE next cycle.
  - `oFrame` unchanged.
  - Next vblank edge runs normally.
- **Gating and re-entry:** `iEnable`=0 across a vblank edge → `oBusy` stays 0. Holding `iPy`=480 for many cycles → only one sequence, because the edge is detected once.
- **Reset mid-sequence:** `iRST` asserted during WAIT → all outputs at reset values next cycle, with no `oStart`. `oFrame` wraps from 16'hFFFF to 0 after a completed sequence.
